gps_cfg_sequencer: RTL and testbench

GPS_CFG_SEQUENCER -- requirements
Module: gps_cfg_sequencer

---
 rtl/gps_cfg_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_gps_cfg_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_cfg_sequencer.sv
// GPS signal-generator configuration sequencer.
// Collects register writes into a shadow bank and commits them to the
// generator either right away (IDLE) or on a code epoch (RUN), so that a
// configuration change always lands on an epoch boundary. While running,
// it also streams navigation message bytes out MSB first, one bit per
// EPOCHS_PER_BIT epochs, through a single-byte holding register.
module gps_cfg_sequencer #(
    parameter int EPOCHS_PER_BIT = 20
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        cfg_ready,
    input  logic        epoch_in,
    output logic        ena_out,
    output logic [4:0]  n_sat_out,
    output logic [15:0] ca_phase_out,
    output logic [7:0]  doppler_out,
    output logic [7:0]  snr_out,
    output logic        noise_off_out,
    output logic        signal_off_out,
    output logic        msg_out,
    output logic        msg_req_out,
    output logic        underrun_out
);

    localparam int              CNT_W    = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EPOCHS_PER_BIT - 1);

    localparam logic [2:0] A_NSAT   = 3'd0;
    localparam logic [2:0] A_PH_LO  = 3'd1;
    localparam logic [2:0] A_PH_HI  = 3'd2;
    localparam logic [2:0] A_DOP    = 3'd3;
    localparam logic [2:0] A_SNR    = 3'd4;
    localparam logic [2:0] A_CTRL   = 3'd5;
    localparam logic [2:0] A_MSG    = 3'd6;
    localparam logic [2:0] A_COMMIT = 3'd7;

    localparam logic [7:0] SNR_MAX = 8'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Generator-facing configuration; the run bit lives in the FSM state.
    typedef struct packed {
        logic [4:0]  n_sat;
        logic [15:0] ca_phase;
        logic [7:0]  doppler;
        logic [7:0]  snr;
        logic        noise_off;
        logic        signal_off;
    } gen_cfg_t;

    state_e           state_q,      state_d;
    gen_cfg_t         shadow_q,     shadow_d;
    logic             sh_run_q,     sh_run_d;
    gen_cfg_t         committed_q,  committed_d;
    logic             pending_q,    pending_d;
    logic [7:0]       hold_q,       hold_d;
    logic             hold_full_q,  hold_full_d;
    logic [7:0]       active_q,     active_d;
    logic             act_valid_q,  act_valid_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [CNT_W-1:0] epoch_cnt_q,  epoch_cnt_d;
    logic             msg_q,        msg_d;
    logic             underrun_q,   underrun_d;

    logic wr_accept;
    logic apply_commit;
    logic start_byte;
    logic load_hold;

    // Writes are refused while a commit waits, and message writes while the holding byte is occupied.
    assign cfg_ready = ~pending_q & ~((cfg_addr == A_MSG) & hold_full_q);

    assign wr_accept    = cfg_valid & cfg_ready;
    assign apply_commit = pending_q & ((state_q == ST_IDLE) | epoch_in);

    // Next-state logic: commit application, FSM transitions, bit timing, message pipeline and register writes.
    always_comb begin
        // NOTE: every value written here gets a default first so no path can leave a latch behind.
        state_d     = state_q;
        shadow_d    = shadow_q;
        sh_run_d    = sh_run_q;
        committed_d = committed_q;
        pending_d   = pending_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        active_d    = active_q;
        act_valid_d = act_valid_q;
        bit_idx_d   = bit_idx_q;
        epoch_cnt_d = epoch_cnt_q;
        msg_d       = msg_q;
        underrun_d  = underrun_q;
        start_byte  = 1'b0;
        load_hold   = 1'b0;

        if (apply_commit) begin
            committed_d = shadow_q;
            pending_d   = 1'b0;
            underrun_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (apply_commit && sh_run_q) begin
                    state_d     = ST_RUN;
                    epoch_cnt_d = '0;
                    start_byte  = 1'b1;
                end
            end
            ST_RUN: begin
                if (apply_commit && !sh_run_q) begin
                    state_d     = ST_IDLE;
                    epoch_cnt_d = '0;
                    bit_idx_d   = '0;
                    act_valid_d = 1'b0;
                    msg_d       = 1'b0;
                end else if (epoch_in) begin
                    if (epoch_cnt_q == CNT_LAST) begin
                        epoch_cnt_d = '0;
                        if (act_valid_q && (bit_idx_q != 3'd7)) begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            msg_d     = active_q[3'd6 - bit_idx_q];
                        end else begin
                            start_byte = 1'b1;
                        end
                    end else begin
                        epoch_cnt_d = epoch_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new byte is due: take it from holding, or flag an underrun and hold the line low.
        if (start_byte) begin
            bit_idx_d = '0;
            if (hold_full_q) begin
                active_d    = hold_q;
                act_valid_d = 1'b1;
                msg_d       = hold_q[7];
                load_hold   = 1'b1;
            end else begin
                act_valid_d = 1'b0;
                msg_d       = 1'b0;
                underrun_d  = 1'b1;
            end
        end

        // A same-cycle message write refills holding after the load empties it.
        hold_full_d = hold_full_q & ~load_hold;

        if (wr_accept) begin
            case (cfg_addr)
                A_NSAT:   shadow_d.n_sat          = cfg_data[4:0];
                A_PH_LO:  shadow_d.ca_phase[7:0]  = cfg_data;
                A_PH_HI:  shadow_d.ca_phase[15:8] = cfg_data;
                A_DOP:    shadow_d.doppler        = cfg_data;
                A_SNR:    shadow_d.snr            = (cfg_data > SNR_MAX) ? SNR_MAX : cfg_data;
                A_CTRL: begin
                    sh_run_d            = cfg_data[0];
                    shadow_d.noise_off  = cfg_data[1];
                    shadow_d.signal_off = cfg_data[2];
                end
                A_MSG: begin
                    hold_d      = cfg_data;
                    hold_full_d = 1'b1;
                end
                A_COMMIT: pending_d = 1'b1;
                default: ;
            endcase
        end
    end

    // State register; reset clears everything so no half-applied commit survives.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            sh_run_q    <= 1'b0;
            committed_q <= '0;
            pending_q   <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            active_q    <= '0;
            act_valid_q <= 1'b0;
            bit_idx_q   <= '0;
            epoch_cnt_q <= '0;
            msg_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            sh_run_q    <= sh_run_d;
            committed_q <= committed_d;
            pending_q   <= pending_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            active_q    <= active_d;
            act_valid_q <= act_valid_d;
            bit_idx_q   <= bit_idx_d;
            epoch_cnt_q <= epoch_cnt_d;
            msg_q       <= msg_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ena_out        = (state_q == ST_RUN);
    assign n_sat_out      = committed_q.n_sat;
    assign ca_phase_out   = committed_q.ca_phase;
    assign doppler_out    = committed_q.doppler;
    assign snr_out        = committed_q.snr;
    assign noise_off_out  = committed_q.noise_off;
    assign signal_off_out = committed_q.signal_off;
    assign msg_out        = msg_q;
    assign msg_req_out    = ~hold_full_q;
    assign underrun_out   = underrun_q;

endmodule

// File: tb/tb_gps_cfg_sequencer.sv
// Testbench for gps_cfg_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_gps_cfg_sequencer;

    localparam int E = 20;

    logic        clk_in = 1'b0;
    logic        rst_in_n;
    logic        cfg_valid;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        epoch_in;
    logic        ena_out;
    logic [4:0]  n_sat_out;
    logic [15:0] ca_phase_out;
    logic [7:0]  doppler_out;
    logic [7:0]  snr_out;
    logic        noise_off_out;
    logic        signal_off_out;
    logic        msg_out;
    logic        msg_req_out;
    logic        underrun_out;

    gps_cfg_sequencer #(.EPOCHS_PER_BIT(E)) dut (
        .clk_in        (clk_in),
        .rst_in_n      (rst_in_n),
        .cfg_valid     (cfg_valid),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .epoch_in      (epoch_in),
        .ena_out       (ena_out),
        .n_sat_out     (n_sat_out),
        .ca_phase_out  (ca_phase_out),
        .doppler_out   (doppler_out),
        .snr_out       (snr_out),
        .noise_off_out (noise_off_out),
        .signal_off_out(signal_off_out),
        .msg_out       (msg_out),
        .msg_req_out   (msg_req_out),
        .underrun_out  (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: configuration as plain fields, message as queues.
    logic [4:0]  s_nsat, c_nsat;
    logic [15:0] s_ph,   c_ph;
    logic [7:0]  s_dop,  c_dop;
    logic [7:0]  s_snr,  c_snr;
    logic [2:0]  s_ctrl;
    logic        c_noff, c_soff;
    bit          m_run, m_pend, m_under;
    int          m_ecnt;
    logic [7:0]  hold_bytes[$];
    bit          bits[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready(input logic [2:0] a);
        return !m_pend && !((a == 3'd6) && (hold_bytes.size() != 0));
    endfunction

    function automatic bit m_msg();
        return (m_run && bits.size() != 0) ? bits[0] : 1'b0;
    endfunction

    task automatic model_reset();
        s_nsat = '0; s_ph = '0; s_dop = '0; s_snr = '0; s_ctrl = '0;
        c_nsat = '0; c_ph = '0; c_dop = '0; c_snr = '0; c_noff = 0; c_soff = 0;
        m_run = 0; m_pend = 0; m_under = 0; m_ecnt = 0;
        hold_bytes.delete();
        bits.delete();
    endtask

    // Start a new byte: unpack the waiting byte into bits, or record an underrun.
    task automatic next_byte();
        logic [7:0] b;
        if (hold_bytes.size() != 0) begin
            b = hold_bytes.pop_front();
            for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
        end else begin
            m_under = 1;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit acc, apply, was_run;
        acc     = cfg_valid && m_ready(cfg_addr);
        apply   = m_pend && (!m_run || epoch_in);
        was_run = m_run;
        if (apply) begin
            c_nsat = s_nsat; c_ph = s_ph; c_dop = s_dop; c_snr = s_snr;
            c_noff = s_ctrl[1]; c_soff = s_ctrl[2];
            m_pend = 0; m_under = 0;
        end
        if (!was_run) begin
            if (apply && s_ctrl[0]) begin
                m_run = 1; m_ecnt = 0; bits.delete();
                next_byte();
            end
        end else if (apply && !s_ctrl[0]) begin
            m_run = 0; m_ecnt = 0; bits.delete();
        end else if (epoch_in) begin
            m_ecnt++;
            if (m_ecnt == E) begin
                m_ecnt = 0;
                if (bits.size() != 0) void'(bits.pop_front());
                if (bits.size() == 0) next_byte();
            end
        end
        if (acc) begin
            case (cfg_addr)
                3'd0: s_nsat = cfg_data[4:0];
                3'd1: s_ph[7:0] = cfg_data;
                3'd2: s_ph[15:8] = cfg_data;
                3'd3: s_dop = cfg_data;
                3'd4: s_snr = (cfg_data > 8) ? 8'd8 : cfg_data;
                3'd5: s_ctrl = cfg_data[2:0];
                3'd6: hold_bytes.push_back(cfg_data);
                default: m_pend = 1;
            endcase
        end
    endtask

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("ena_out",        ena_out,        m_run);
            check("n_sat_out",      n_sat_out,      c_nsat);
            check("ca_phase_out",   ca_phase_out,   c_ph);
            check("doppler_out",    doppler_out,    c_dop);
            check("snr_out",        snr_out,        c_snr);
            check("noise_off_out",  noise_off_out,  c_noff);
            check("signal_off_out", signal_off_out, c_soff);
            check("msg_out",        msg_out,        m_msg());
            check("msg_req_out",    msg_req_out,    hold_bytes.size() == 0);
            check("underrun_out",   underrun_out,   m_under);
            check("cfg_ready",      cfg_ready,      m_ready(cfg_addr));
        end
    end

    task automatic tick(input logic v, input logic [2:0] a, input logic [7:0] d, input logic e);
        cfg_valid = v; cfg_addr = a; cfg_data = d; epoch_in = e;
        @(posedge clk_in);
        if (rst_in_n) model_step();
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        tick(1'b1, a, d, 1'b0);
    endtask

    task automatic epochs(input int n);
        repeat (n) begin
            tick(1'b0, 3'd0, 8'h00, 1'b1);
            tick(1'b0, 3'd0, 8'h00, 1'b0);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_in_n = 1'b0;
        model_reset();
        #1;
        repeat (cycles) tick(1'b0, 3'd0, 8'h00, 1'b0);
        rst_in_n = 1'b1;
    endtask

    logic [15:0] seq_a5_3c = 16'b1010_0101_0011_1100;

    initial begin
        rst_in_n = 1'b0; cfg_valid = 0; cfg_addr = 0; cfg_data = 0; epoch_in = 0;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        cmp_en = 1'b1;
        check("rst_ena", ena_out, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_msg_req", msg_req_out, 1'b1);
        rst_in_n = 1'b1;

        // IDLE commit: masked n_sat and ctrl, applied one cycle after commit.
        wr(3'd0, 8'hE5);
        wr(3'd3, 8'h20);
        wr(3'd5, 8'hF9);
        wr(3'd7, 8'h00);
        check("shadow_only", n_sat_out, 5'd0);
        tick(1'b0, 3'd0, 8'h00, 1'b0);
        check("idle_nsat", n_sat_out, 5'd5);
        check("idle_dop", doppler_out, 8'h20);
        check("idle_ena", ena_out, 1'b1);
        check("start_underrun", underrun_out, 1'b1);

        // RUN commit waits for an epoch; snr clamped to 8.
        wr(3'd4, 8'd12);
        wr(3'd7, 8'h00);
        repeat (3) tick(1'b0, 3'd0, 8'h00, 1'b0);
        check("run_wait_ready", cfg_ready, 1'b0);
        check("run_wait_snr", snr_out, 8'd0);
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        check("run_snr", snr_out, 8'd8);
        check("run_ready", cfg_ready, 1'b1);
        check("commit_clr_under", underrun_out, 1'b0);

        // Stop, then stream 0xA5, 0x3C.
        wr(3'd5, 8'h00);
        wr(3'd7, 8'h00);
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        check("stop_ena", ena_out, 1'b0);
        wr(3'd6, 8'hA5);
        check("hold_req", msg_req_out, 1'b0);
        wr(3'd5, 8'h01);
        wr(3'd7, 8'h00);
        tick(1'b0, 3'd0, 8'h00, 1'b0);
        wr(3'd6, 8'h3C);
        for (int b = 0; b < 16; b++) begin
            check($sformatf("seq_bit%0d", b), msg_out, seq_a5_3c[15-b]);
            epochs(E);
        end
        check("drain_under", underrun_out, 1'b1);
        check("drain_msg", msg_out, 1'b0);
        wr(3'd6, 8'h80);
        epochs(E);
        check("late_byte_msg", msg_out, 1'b1);
        check("under_sticky", underrun_out, 1'b1);
        wr(3'd7, 8'h00);
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        check("commit_clears", underrun_out, 1'b0);
        check("still_run", ena_out, 1'b1);

        // Holding full blocks message writes; stop commit lands on an epoch.
        wr(3'd6, 8'h11);
        tick(1'b0, 3'd6, 8'h00, 1'b0);
        check("full_not_ready", cfg_ready, 1'b0);
        wr(3'd5, 8'h00);
        wr(3'd7, 8'h00);
        tick(1'b0, 3'd0, 8'h00, 1'b0);
        check("stop_wait_ena", ena_out, 1'b1);
        tick(1'b0, 3'd0, 8'h00, 1'b1);
        check("stop_ena2", ena_out, 1'b0);
        check("stop_msg", msg_out, 1'b0);

        // Reset in the middle of a run with a commit still pending.
        wr(3'd0, 8'h1F);
        wr(3'd1, 8'h34);
        wr(3'd2, 8'h12);
        wr(3'd5, 8'h07);
        wr(3'd7, 8'h00);
        tick(1'b0, 3'd0, 8'h00, 1'b0);
        check("pre_rst_ph", ca_phase_out, 16'h1234);
        epochs(5);
        wr(3'd4, 8'h03);
        wr(3'd7, 8'h00);
        do_reset(2);
        check("mid_rst_ena", ena_out, 1'b0);
        check("mid_rst_ph", ca_phase_out, 16'h0000);
        check("mid_rst_req", msg_req_out, 1'b1);
        check("mid_rst_ready", cfg_ready, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic v, e;
            logic [2:0] a;
            logic [7:0] d;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
            end else begin
                v = ($urandom_range(0, 2) == 0);
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                e = ($urandom_range(0, 4) < 2);
                if (a == 3'd5 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                tick(v, a, d, e);
            end
        end

        tick(1'b0, 3'd0, 8'h00, 1'b0);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
